// File: rtl/gpio_reg_ctrl_pkg.sv
// Shared constants and types for the GPIO register controller: register/op codes,
// sequencer states and the latched command record.
package gpio_reg_ctrl_pkg;

  localparam logic [1:0] GPIO_REG_DDRA  = 2'b00;
  localparam logic [1:0] GPIO_REG_DDRB  = 2'b01;
  localparam logic [1:0] GPIO_REG_PORTA = 2'b10;
  localparam logic [1:0] GPIO_REG_PORTB = 2'b11;

  localparam logic [1:0] GPIO_OP_WRITE = 2'b00;
  localparam logic [1:0] GPIO_OP_SET   = 2'b01;
  localparam logic [1:0] GPIO_OP_CLR   = 2'b10;
  localparam logic [1:0] GPIO_OP_TGL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic       who;
    logic       we;
    logic [1:0] op;
    logic [1:0] addr;
  } cmd_t;

endpackage

// File: rtl/gpio_reg_ctrl_if.sv
// One requester's register-access channel (request handshake plus done pulse).
interface gpio_reg_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [1:0]            op;
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  done;

  modport master (output valid, we, op, addr, wdata, input ready, done);
  modport slave  (input valid, we, op, addr, wdata, output ready, done);
endinterface

// File: rtl/gpio_reg_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, on a tie the one not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end
endmodule

// File: rtl/gpio_reg_ctrl.sv
// GPIO configuration register file shared by two requesters via a 3-state sequencer.
// Define GPIO_ATOMIC_OPS_EN to decode SET/CLR/TGL; otherwise every write is a plain WRITE.
module gpio_reg_ctrl
  import gpio_reg_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DDR_RST    = '0,
  parameter logic [DATA_WIDTH-1:0] PORT_RST   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  gpio_reg_ctrl_if.slave        req0,
  gpio_reg_ctrl_if.slave        req1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] mem_ddra,
  output logic [DATA_WIDTH-1:0] mem_ddrb,
  output logic [DATA_WIDTH-1:0] mem_porta,
  output logic [DATA_WIDTH-1:0] mem_portb
);

  state_e                     state_q, state_d;
  logic                       last_grant_q;
  cmd_t                       cmd_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic [3:0][DATA_WIDTH-1:0] regs_q;
  logic [1:0]                 grant;
  logic [DATA_WIDTH-1:0]      wb_val;

  rr_arbiter2 u_arb (
    .valid      ({req1.valid, req0.valid}),
    .last_grant (last_grant_q),
    .enable     (state_q == S_IDLE),
    .grant      (grant)
  );

  assign req0.ready = grant[0];
  assign req1.ready = grant[1];
  assign req0.done  = (state_q == S_RESP) && !cmd_q.who;
  assign req1.done  = (state_q == S_RESP) &&  cmd_q.who;
  assign busy       = (state_q != S_IDLE);
  assign rdata      = rdata_q;

  assign mem_ddra  = regs_q[GPIO_REG_DDRA];
  assign mem_ddrb  = regs_q[GPIO_REG_DDRB];
  assign mem_porta = regs_q[GPIO_REG_PORTA];
  assign mem_portb = regs_q[GPIO_REG_PORTB];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|grant) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == S_RESP) last_grant_q <= cmd_q.who;
    end
  end

  // Command latch: the winner's fields are captured on the accept edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q   <= '0;
      wdata_q <= '0;
    end else if (state_q == S_IDLE && |grant) begin
      if (grant[1]) begin
        cmd_q   <= '{who: 1'b1, we: req1.we, op: req1.op, addr: req1.addr};
        wdata_q <= req1.wdata;
      end else begin
        cmd_q   <= '{who: 1'b0, we: req0.we, op: req0.op, addr: req0.addr};
        wdata_q <= req0.wdata;
      end
    end
  end

`ifdef GPIO_ATOMIC_OPS_EN
  logic [DATA_WIDTH-1:0] cur_val;
  always_comb begin
    cur_val = regs_q[cmd_q.addr];
    wb_val  = wdata_q;
    case (cmd_q.op)
      GPIO_OP_WRITE: wb_val = wdata_q;
      GPIO_OP_SET:   wb_val = cur_val | wdata_q;
      GPIO_OP_CLR:   wb_val = cur_val & ~wdata_q;
      GPIO_OP_TGL:   wb_val = cur_val ^ wdata_q;
      default:       wb_val = wdata_q;
    endcase
  end
`else
  logic unused_op;
  assign unused_op = ^cmd_q.op;
  assign wb_val    = wdata_q;
`endif

  // rdata captures the pre-op value; only the addressed register is written back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q   <= '0;
      regs_q[0] <= DDR_RST;
      regs_q[1] <= DDR_RST;
      regs_q[2] <= PORT_RST;
      regs_q[3] <= PORT_RST;
    end else if (state_q == S_EXEC) begin
      rdata_q <= regs_q[cmd_q.addr];
      if (cmd_q.we) regs_q[cmd_q.addr] <= wb_val;
    end
  end

endmodule
